truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2: number of cycles each input vector is held before sampling; legal range 1..15.
REQ-002 The block SHALL have parameter EXPECTED, default 16'h0000: golden truth table, bit i = expected output for vector i.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a 16-vector sweep.
REQ-007 abort  input  1  terminate the sweep in progress.
REQ-008 dut_out  input  1  output of the 4-input circuit under control.
REQ-009 first_in, second_in, third_in, fourth_in  output  1 each  drive to the circuit; first_in is the MSB of the vector index.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 table_out  output  16  captured truth table, bit i = dut_out sampled for vector i.
REQ-013 mismatch  output  1  captured table differs from EXPECTED (valid from done onward).
REQ-014 mismatch_count  output  5  number of differing bits, 0..16.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE.
REQ-016 In IDLE, start=1 SHALL move to DRIVE, set index to 0, clear table_out, mismatch and mismatch_count, and assert busy from the next cycle.
REQ-017 In DRIVE, the drive outputs SHALL equal the 4-bit index; after SETTLE cycles in DRIVE the FSM SHALL move to SAMPLE.
REQ-018 In SAMPLE (one cycle), table_out[index] SHALL load dut_out; the drive outputs SHALL stay unchanged; index 15 -> DONE, otherwise increment index -> DRIVE.
REQ-019 In DONE, done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 If start is sampled in cycle T, done SHALL be high in cycle T+1+16*(SETTLE+1).
REQ-021 start SHALL be ignored when not in IDLE, including in the DONE cycle.
REQ-022 abort=1 in DRIVE or SAMPLE SHALL return to IDLE next cycle: drive outputs 0, busy 0, no done pulse, table_out retains partial captures; abort has priority over the SAMPLE capture in the same cycle.
REQ-023 abort in IDLE or DONE SHALL have no effect; start and abort both high in IDLE SHALL start the sweep.
REQ-024 In IDLE the drive outputs SHALL be 0; table_out, mismatch and mismatch_count SHALL hold until the next start.
REQ-025 The index SHALL not wrap: after vector 15 it is not incremented.

Reset
REQ-026 rst_n=0 SHALL force IDLE immediately with index 0, all drive outputs 0, busy 0, done 0, table_out 0, mismatch 0, mismatch_count 0, including mid-sweep.
REQ-027 After rst_n deasserts, the block SHALL wait for start; no sweep self-starts.

Configuration
REQ-028 With macro TT_COMPARE_EN defined, each SAMPLE SHALL compare dut_out with EXPECTED[index], increment mismatch_count on difference, and set mismatch when the count is nonzero.
REQ-029 Without TT_COMPARE_EN, mismatch and mismatch_count SHALL be constant 0, EXPECTED SHALL be unused, and no compare logic SHALL be synthesized.

Structure
REQ-030 Package tt_seq_pkg SHALL hold the state typedef (IDLE, DRIVE, SAMPLE, DONE), NUM_VECTORS=16 and IDX_W=4.
REQ-031 The hold timing SHALL be a sub-module, settle_counter: load on DRIVE entry, terminal-count flag after SETTLE cycles.

Verification
REQ-032 XOR model dut_out=^index, SETTLE=2, EXPECTED=16'h6996, start at T -> done at T+49, table_out=16'h6996, mismatch=0, count=0.
REQ-033 Same run with EXPECTED=16'h6997 and TT_COMPARE_EN defined -> mismatch=1, mismatch_count=1; without the macro -> both 0.
REQ-034 Abort asserted during vector 5 -> IDLE next cycle, no done pulse, table_out bits 0..4 captured and bits 5..15 = 0.
REQ-035 rst_n pulsed low during vector 9 -> all outputs 0 within the same cycle; a subsequent start runs a full sweep to done.
REQ-036 start re-pulsed while busy and in the DONE cycle -> ignored: exactly one done per accepted start; drive sequence 0..15 in order, each held SETTLE+1 cycles.

Source files
------------

// File: rtl/tt_seq_pkg.sv
// Shared types and sizes for the truth-table sequencer.
// Optional compare logic is enabled by the TT_COMPARE_EN macro.
package tt_seq_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/truth_table_sequencer_settle.sv
// Hold-time counter: loaded on DRIVE entry, flags terminal count after SETTLE cycles.
// SETTLE legal range is 1..15.
module settle_counter #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= 4'(SETTLE - 1);
        end else if (en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt == 4'd0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input circuit through all 16 vectors and captures its truth table.
// Define TT_COMPARE_EN to compare the captured table against EXPECTED.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic        first_in,
    output logic        second_in,
    output logic        third_in,
    output logic        fourth_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        mismatch,
    output logic [4:0]  mismatch_count
);

    state_t           state;
    state_t           next;
    logic [IDX_W-1:0] idx;
    logic             load;
    logic             tc;
    logic             clear;
    logic             capture;
    logic             last;

    assign last    = (idx == IDX_W'(NUM_VECTORS - 1));
    assign clear   = (state == IDLE) && start;
    assign capture = (state == SAMPLE) && !abort;

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (state == DRIVE),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        load = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next = DRIVE;
                    load = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    next = IDLE;
                end else if (tc) begin
                    next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    next = IDLE;
                end else if (last) begin
                    next = DONE;
                end else begin
                    next = DRIVE;
                    load = 1'b1;
                end
            end
            DONE: begin
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            table_out <= '0;
        end else if (clear) begin
            idx       <= '0;
            table_out <= '0;
        end else if (capture) begin
            table_out[idx] <= dut_out;
            if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Drive lines are only live while a vector is being presented.
    always_comb begin
        {first_in, second_in, third_in, fourth_in} = '0;
        if (state == DRIVE || state == SAMPLE) begin
            {first_in, second_in, third_in, fourth_in} = idx;
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);

`ifdef TT_COMPARE_EN
    logic [4:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (capture && (dut_out != EXPECTED[idx])) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign mismatch_count = cnt_q;
    assign mismatch       = (cnt_q != 5'd0);
`else
    assign mismatch_count = 5'd0;
    assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized bench for truth_table_sequencer against a table-level model.
// Expected compare results follow the TT_COMPARE_EN macro.
module tb_truth_table_sequencer;

    localparam int          S   = 2;
    localparam logic [15:0] EXP = 16'h6997;
    localparam int          SWEEP = 16 * (S + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dut_out;
    logic        first_in, second_in, third_in, fourth_in;
    logic        busy, done;
    logic [15:0] table_out;
    logic        mismatch;
    logic [4:0]  mismatch_count;

    logic [15:0] fn = 16'h0000;
    logic [3:0]  vec;
    int          n_chk = 0;
    int          n_fail = 0;

    assign vec     = {first_in, second_in, third_in, fourth_in};
    assign dut_out = fn[vec];

    always #5 clk = ~clk;

    truth_table_sequencer #(
        .SETTLE   (S),
        .EXPECTED (EXP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_out        (dut_out),
        .first_in       (first_in),
        .second_in      (second_in),
        .third_in       (third_in),
        .fourth_in      (fourth_in),
        .busy           (busy),
        .done           (done),
        .table_out      (table_out),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count)
    );

    function automatic logic [4:0] exp_cnt(input logic [15:0] f);
`ifdef TT_COMPARE_EN
        return 5'($countones(f ^ EXP));
`else
        return 5'd0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, done, vec, table_out, mismatch, mismatch_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b vec=%h table=%h mm=%b cnt=%0d required all 0",
                     busy, done, vec, table_out, mismatch, mismatch_count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_self_start: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic run_sweep(input logic [15:0] f, input bit repulse, input string tag);
        int done_at = 0;
        int dones = 0;
        int bad = 0;
        logic [15:0] t_seen = '0;
        logic        m_seen = 1'b0;
        logic [4:0]  c_seen = '0;
        fn = f;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= SWEEP + 20; k++) begin
            if (done === 1'b1) begin
                dones++;
                if (done_at == 0) begin
                    done_at = k;
                    t_seen = table_out;
                    m_seen = mismatch;
                    c_seen = mismatch_count;
                end
                if (busy !== 1'b0) bad++;
            end
            if (k <= SWEEP) begin
                if (busy !== 1'b1 || vec !== 4'((k - 1) / (S + 1))) bad++;
            end
            start = 1'b0;
            if (repulse && done === 1'b1) start = 1'b1;
            if (repulse && busy === 1'b1 && $urandom_range(0, 3) == 0) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        n_chk++;
        if (done_at != SWEEP + 1) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d required %0d", tag, done_at, SWEEP + 1);
        end
        n_chk++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d required 1", tag, dones);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s drive_sequence: %0d bad cycles required 0", tag, bad);
        end
        n_chk++;
        if (t_seen !== f) begin
            n_fail++;
            $display("FAIL %s table_out: got %h required %h", tag, t_seen, f);
        end
        n_chk++;
        if (c_seen !== exp_cnt(f) || m_seen !== (exp_cnt(f) != 0)) begin
            n_fail++;
            $display("FAIL %s compare: mm=%b cnt=%0d required %b %0d",
                     tag, m_seen, c_seen, exp_cnt(f) != 0, exp_cnt(f));
        end
        n_chk++;
        if (table_out !== f || busy !== 1'b0 || vec !== 4'd0) begin
            n_fail++;
            $display("FAIL %s idle_hold: table=%h busy=%b vec=%h required %h 0 0",
                     tag, table_out, busy, vec, f);
        end
    endtask

    task automatic test_xor();
        run_sweep(16'h6996, 1'b0, "xor");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            run_sweep(16'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_sweep(16'($urandom), 1'b1, "repulse");
        run_sweep(16'($urandom), 1'b1, "repulse2");
    endtask

    task automatic test_abort();
        int at;
        int dones = 0;
        logic [15:0] f;
        for (int r = 0; r <= S; r++) begin
            f  = 16'($urandom) | 16'h0020;
            fn = f;
            at = 1 + 5 * (S + 1) + r;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k < at; k++) @(negedge clk);
            n_chk++;
            if (vec !== 4'd5) begin
                n_fail++;
                $display("FAIL abort_pos: vec=%h required 5", vec);
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n_chk++;
            if (busy !== 1'b0 || done !== 1'b0 || vec !== 4'd0 ||
                table_out !== (f & 16'h001F)) begin
                n_fail++;
                $display("FAIL abort_state: busy=%b done=%b vec=%h table=%h required 0 0 0 %h",
                         busy, done, vec, table_out, f & 16'h001F);
            end
            dones = 0;
            for (int k = 0; k < SWEEP + 5; k++) begin
                if (done === 1'b1 || busy === 1'b1) dones++;
                @(negedge clk);
            end
            n_chk++;
            if (dones != 0) begin
                n_fail++;
                $display("FAIL abort_no_done: %0d active cycles required 0", dones);
            end
        end
    endtask

    task automatic test_abort_idle();
        logic [15:0] held;
        held  = table_out;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || table_out !== held) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b table=%h required 0 %h", busy, table_out, held);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || vec !== 4'd0 || table_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b vec=%h table=%h required 1 0 0000",
                     busy, vec, table_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        fn = 16'($urandom) | 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 2 + 9 * (S + 1); k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, vec, table_out, mismatch, mismatch_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b vec=%h table=%h mm=%b cnt=%0d required all 0",
                     busy, done, vec, table_out, mismatch, mismatch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b required 0", busy);
        end
        run_sweep(16'($urandom), 1'b0, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_xor();
        test_random();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
